// File: rtl/cke_period_meter_if.sv
// Signal bundle between a measured pulse/enable source and cke_period_meter.
// The slave modport is the meter. The master modport is the side that drives sig/en and reads results.
interface cke_period_meter_if #(
  parameter int MAX_T = 50000000
);
  localparam int W = $clog2(MAX_T + 1);

  logic         sig;
  logic         en;
  logic [W-1:0] period;
  logic [W-1:0] high;
  logic         valid;
  logic         timeout;

  modport master (
    output sig,
    output en,
    input  period,
    input  high,
    input  valid,
    input  timeout
  );

  modport slave (
    input  sig,
    input  en,
    output period,
    output high,
    output valid,
    output timeout
  );
endinterface

// File: rtl/cke_period_meter.sv
// Measures period and high time (in clk cycles) of a possibly asynchronous pulse stream.
// It also flags a source that produces no rising edge within MAX_T cycles.
module cke_period_meter #(
  parameter int MAX_T       = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  cke_period_meter_if.slave bus
);
  localparam int W = $clog2(MAX_T + 1);
  localparam logic [W-1:0] MAX_V  = W'(MAX_T);
  localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   s_s;
  logic                   rise_s;

  state_t       state_r, state_n_s;
  logic [W-1:0] cnt_r, cnt_n_s;
  logic [W-1:0] hcnt_r, hcnt_n_s;
  logic [W-1:0] period_r, period_n_s;
  logic [W-1:0] high_r, high_n_s;
  logic         valid_r, valid_n_s;
  logic         timeout_r, timeout_n_s;

  // Counters stick at MAX_T rather than wrapping.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (v >= MAX_V) begin
      sat_inc = MAX_V;
    end else begin
      sat_inc = v + ONE_V;
    end
  endfunction

  // Synchroniser chain and previous-sample flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.sig};
      prev_r <= s_s;
    end
  end

  assign s_s    = sync_r[SYNC_STAGES-1];
  assign rise_s = s_s & ~prev_r;

  // State, counters and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= ZERO_V;
      hcnt_r    <= ZERO_V;
      period_r  <= ZERO_V;
      high_r    <= ZERO_V;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      cnt_r     <= cnt_n_s;
      hcnt_r    <= hcnt_n_s;
      period_r  <= period_n_s;
      high_r    <= high_n_s;
      valid_r   <= valid_n_s;
      timeout_r <= timeout_n_s;
    end
  end

  // Next-state and next-result logic; en=0 overrides every state.
  always_comb begin
    state_n_s   = state_r;
    cnt_n_s     = cnt_r;
    hcnt_n_s    = hcnt_r;
    period_n_s  = period_r;
    high_n_s    = high_r;
    valid_n_s   = 1'b0;
    timeout_n_s = timeout_r;

    if (!bus.en) begin
      state_n_s   = IDLE;
      cnt_n_s     = ZERO_V;
      hcnt_n_s    = ZERO_V;
      timeout_n_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // cnt counts cycles spent waiting in ARM so a dead source still times out.
          state_n_s = ARM;
          cnt_n_s   = ONE_V;
          hcnt_n_s  = ZERO_V;
        end
        ARM: begin
          if (rise_s) begin
            state_n_s = MEAS;
            cnt_n_s   = ONE_V;
            hcnt_n_s  = ONE_V;
          end else begin
            cnt_n_s  = sat_inc(cnt_r);
            hcnt_n_s = ZERO_V;
            if (cnt_r == MAX_V) begin
              timeout_n_s = 1'b1;
            end else begin
              timeout_n_s = timeout_r;
            end
          end
        end
        MEAS: begin
          // A rise on the MAX_T cycle still counts as a valid period.
          if (rise_s) begin
            period_n_s  = cnt_r;
            high_n_s    = hcnt_r;
            valid_n_s   = 1'b1;
            timeout_n_s = 1'b0;
            cnt_n_s     = ONE_V;
            hcnt_n_s    = ONE_V;
          end else if (cnt_r == MAX_V) begin
            timeout_n_s = 1'b1;
            state_n_s   = ARM;
            cnt_n_s     = ONE_V;
            hcnt_n_s    = ZERO_V;
          end else begin
            cnt_n_s = sat_inc(cnt_r);
            if (s_s) begin
              hcnt_n_s = sat_inc(hcnt_r);
            end else begin
              hcnt_n_s = hcnt_r;
            end
          end
        end
        default: begin
          state_n_s = IDLE;
          cnt_n_s   = ZERO_V;
          hcnt_n_s  = ZERO_V;
        end
      endcase
    end
  end

  assign bus.period  = period_r;
  assign bus.high    = high_r;
  assign bus.valid   = valid_r;
  assign bus.timeout = timeout_r;
endmodule

// File: tb/tb_cke_period_meter.sv
// Randomised scoreboard bench for cke_period_meter against a sample-window reference model.
module tb_cke_period_meter;
  localparam int MAX_T       = 64;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst;

  cke_period_meter_if #(.MAX_T(MAX_T)) bus ();

  cke_period_meter #(.MAX_T(MAX_T), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int high;
  } exp_t;

  typedef enum {M_IDLE, M_ARMED, M_MEAS} mmode_t;

  int     checks = 0;
  int     passes = 0;
  exp_t   exp_q[$];
  bit     mdl_timeout;
  int     last_period;
  int     last_high;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: sig samples delayed by the synchroniser; window = s samples since the last rise.
  initial begin
    bit     sq[$];
    bit     win[$];
    mmode_t mode;
    int     cyc;
    int     arm_start;
    bit     s, p, rise;
    int     h;
    exp_t   e;
    cyc = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        sq.delete();
        for (int i = 0; i <= SYNC_STAGES; i++) sq.push_back(1'b0);
        win.delete();
        exp_q.delete();
        mode        = M_IDLE;
        mdl_timeout = 1'b0;
        last_period = 0;
        last_high   = 0;
      end else begin
        cyc++;
        s    = sq[1];
        p    = sq[0];
        rise = s && !p;
        sq.push_back(bus.sig);
        void'(sq.pop_front());
        if (!bus.en) begin
          mode        = M_IDLE;
          mdl_timeout = 1'b0;
          win.delete();
        end else begin
          case (mode)
            M_IDLE: begin
              mode      = M_ARMED;
              arm_start = cyc;
            end
            M_ARMED: begin
              if (rise) begin
                mode = M_MEAS;
                win.delete();
                win.push_back(1'b1);
              end else if (cyc - arm_start >= MAX_T) begin
                mdl_timeout = 1'b1;
              end
            end
            default: begin
              if (rise) begin
                h = 0;
                foreach (win[i]) h += int'(win[i]);
                e.period    = win.size();
                e.high      = h;
                last_period = e.period;
                last_high   = e.high;
                exp_q.push_back(e);
                mdl_timeout = 1'b0;
                win.delete();
                win.push_back(1'b1);
              end else if (win.size() >= MAX_T) begin
                mdl_timeout = 1'b1;
                mode        = M_ARMED;
                arm_start   = cyc;
                win.delete();
              end else begin
                win.push_back(s);
              end
            end
          endcase
        end
      end
    end
  end

  // Monitor: every expected result must appear as valid on the very next falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("timeout", int'(bus.timeout), int'(mdl_timeout));
        if (bus.valid || exp_q.size() > 0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", int'(bus.valid), 0);
          end else begin
            e = exp_q.pop_front();
            check("valid", int'(bus.valid), 1);
            check("period", int'(bus.period), e.period);
            check("high", int'(bus.high), e.high);
          end
        end
      end
    end
  end

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sig = v;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo;
    rst     = 1'b1;
    bus.sig = 1'b0;
    bus.en  = 1'b0;
    #1;
    check("reset_period", int'(bus.period), 0);
    check("reset_high", int'(bus.high), 0);
    check("reset_valid", int'(bus.valid), 0);
    check("reset_timeout", int'(bus.timeout), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;

    wave(1, 9, 6);
    wave(5, 5, 4);
    wave(7, 3, 4);

    // Single rise then silence, later rises re-arm and then measure.
    wave(1, 150, 1);
    check("timeout_after_silence", int'(bus.timeout), 1);
    wave(1, 9, 1);
    check("timeout_held_while_rearmed", int'(bus.timeout), 1);
    wave(1, 9, 3);
    check("timeout_cleared_by_valid", int'(bus.timeout), 0);

    wave(1, 63, 3);
    wave(1, 64, 3);
    wave(3, 61, 2);

    // en dropped mid-measurement.
    wave(4, 6, 3);
    drive(1'b1, 2);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("en_drop_period_hold", int'(bus.period), last_period);
    check("en_drop_high_hold", int'(bus.high), last_high);
    check("en_drop_timeout", int'(bus.timeout), 0);
    check("en_drop_valid", int'(bus.valid), 0);
    bus.en = 1'b1;
    wave(2, 8, 4);

    // Constant high from before en rises: no rise, timeout.
    bus.sig = 1'b1;
    bus.en  = 1'b0;
    repeat (4) @(negedge clk);
    bus.en = 1'b1;
    drive(1'b1, 140);
    check("const_high_timeout", int'(bus.timeout), 1);
    wave(1, 9, 3);

    // Asynchronous reset between clock edges mid-measurement.
    wave(3, 7, 3);
    drive(1'b1, 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_period", int'(bus.period), 0);
    check("midrst_high", int'(bus.high), 0);
    check("midrst_valid", int'(bus.valid), 0);
    check("midrst_timeout", int'(bus.timeout), 0);
    drive(1'b0, 2);
    rst = 1'b0;
    wave(1, 9, 4);

    for (int k = 0; k < 60; k++) begin
      hi = $urandom_range(1, 12);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(55, 70) : $urandom_range(1, 12);
      drive(1'b1, hi);
      drive(1'b0, lo);
      if ($urandom_range(0, 9) == 0) begin
        bus.en = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus.en = 1'b1;
      end
    end

    repeat (8) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
